aes_host_driver: RTL

- Bus-initiator counterpart of the AES peripheral interface.
- Takes a 128-bit key and a 128-bit plaintext from the host side and writes each to the peripheral as four 32-bit beats.
- Waits for the core to finish, then reads the 128-bit ciphertext back as four 32-bit beats.
- Sits between the system controller and the AES interface; it owns CS, RW and adress.

---
 rtl/aes_host_driver.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/aes_host_driver.sv
// ---------------------------------------------------------------------------
// aes_host_driver
//
// Bus initiator for the AES peripheral. On a start request it latches a
// 128-bit key and a 128-bit plaintext. It writes the key as four 32-bit beats,
// then writes the plaintext as four 32-bit beats. It then waits for the core's
// aes_done level and reads the 128-bit ciphertext back as four 32-bit beats.
// Word 0 of every block is bits [0:31], so the most significant word goes first.
//
// Handshake semantics:
//   start is sampled only while the FSM is IDLE. In any other state it is
//   ignored and not queued. CS is a strobe with one beat per cycle and no
//   back-pressure. The peripheral accepts a write beat, or presents read
//   data, in every cycle in which CS is high.
//
// Ports:
//   clk        system clock; all state changes on the rising edge
//   reset      asynchronous, active-low reset
//   start      request a new encryption (IDLE only)
//   key_in     128-bit key, beat 0 = bits [0:31]
//   msg_in     128-bit plaintext, same beat ordering
//   result     ciphertext assembled from the four read beats
//   busy       high in every state except IDLE
//   done       one-cycle pulse when result is complete
//   error      one-cycle pulse when WAIT times out
//   CS         bus beat strobe
//   RW         1 = read, 0 = write
//   adress     1 = key register, 0 = message register
//   bus_wdata  write beat data
//   bus_oe     drive enable for bus_wdata, high only on write beats
//   bus_rdata  read beat data from the peripheral
//   aes_done   level from the AES core: ciphertext available
//
// Optional feature (macro AES_HOST_KEY_CACHE_EN):
//   Remembers the last key that was written. If a new request carries the
//   same key, the four key beats are skipped.
// ---------------------------------------------------------------------------
module aes_host_driver #(
   parameter int TIMEOUT = 64,
   parameter int DATA_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [0:127]      key_in,
   input  logic [0:127]      msg_in,
   output logic [0:127]      result,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic              CS,
   output logic              RW,
   output logic              adress,
   output logic [0:DATA_W-1] bus_wdata,
   output logic              bus_oe,
   input  logic [0:DATA_W-1] bus_rdata,
   input  logic              aes_done
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WR_KEY = 3'd1,
      WR_MSG = 3'd2,
      WAIT   = 3'd3,
      RD_CT  = 3'd4,
      DONE   = 3'd5
   } state_t;

   state_t          state, state_n;
   logic [1:0]      beat, beat_n;
   logic [TW-1:0]   tmo_cnt, tmo_n;
   logic [0:127]    key_q, msg_q;
   logic [0:127]    key_src, msg_src;
   logic            cache_hit;
   logic            timeout_ev;

   // Registered-output next values
   logic              cs_d, rw_d, adr_d, oe_d, busy_d, done_d, error_d;
   logic [0:DATA_W-1] wdata_d;

`ifdef AES_HOST_KEY_CACHE_EN
   logic [0:127] last_key;
   logic         key_valid;

   assign cache_hit = key_valid && (key_in == last_key);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_key  <= '0;
         key_valid <= 1'b0;
      end else if (state == WR_KEY && beat == 2'd3) begin
         last_key  <= key_q;
         key_valid <= 1'b1;
      end else if (timeout_ev) begin
         key_valid <= 1'b0;
      end
   end
`else
   assign cache_hit = 1'b0;
`endif

   assign timeout_ev = (state == WAIT) && (state_n == IDLE);

   // In IDLE the copies are being loaded on the same edge, so the first beat
   // has to come straight from the inputs.
   assign key_src = (state == IDLE) ? key_in : key_q;
   assign msg_src = (state == IDLE) ? msg_in : msg_q;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         beat    <= 2'd0;
         tmo_cnt <= '0;
      end else begin
         state   <= state_n;
         beat    <= beat_n;
         tmo_cnt <= tmo_n;
      end
   end

   // Next-state logic
   always_comb begin
      state_n = state;
      beat_n  = beat;
      tmo_n   = '0;
      case (state)
         IDLE: begin
            if (start) begin
               beat_n  = 2'd0;
               state_n = cache_hit ? WR_MSG : WR_KEY;
            end
         end
         WR_KEY: begin
            beat_n = beat + 2'd1;
            if (beat == 2'd3) state_n = WR_MSG;
         end
         WR_MSG: begin
            beat_n = beat + 2'd1;
            if (beat == 2'd3) state_n = WAIT;
         end
         WAIT: begin
            // aes_done wins over a timeout that lands on the same edge.
            if (aes_done) begin
               state_n = RD_CT;
               beat_n  = 2'd0;
            end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
               state_n = IDLE;
            end else begin
               tmo_n = tmo_cnt + TW'(1);
            end
         end
         RD_CT: begin
            beat_n = beat + 2'd1;
            if (beat == 2'd3) state_n = DONE;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Output decode. The values come from the state being entered, so the
   // registered outputs line up with that state's cycle.
   always_comb begin
      cs_d    = 1'b0;
      rw_d    = 1'b0;
      adr_d   = 1'b0;
      oe_d    = 1'b0;
      wdata_d = '0;
      case (state_n)
         WR_KEY: begin
            cs_d    = 1'b1;
            adr_d   = 1'b1;
            oe_d    = 1'b1;
            wdata_d = key_src[{beat_n, 5'd0} +: DATA_W];
         end
         WR_MSG: begin
            cs_d    = 1'b1;
            oe_d    = 1'b1;
            wdata_d = msg_src[{beat_n, 5'd0} +: DATA_W];
         end
         RD_CT: begin
            cs_d = 1'b1;
            rw_d = 1'b1;
         end
         default: ;
      endcase
      busy_d  = (state_n != IDLE);
      done_d  = (state_n == DONE);
      error_d = timeout_ev;
   end

   // Output registers and datapath
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         CS        <= 1'b0;
         RW        <= 1'b0;
         adress    <= 1'b0;
         bus_oe    <= 1'b0;
         bus_wdata <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         result    <= '0;
         key_q     <= '0;
         msg_q     <= '0;
      end else begin
         CS        <= cs_d;
         RW        <= rw_d;
         adress    <= adr_d;
         bus_oe    <= oe_d;
         bus_wdata <= wdata_d;
         busy      <= busy_d;
         done      <= done_d;
         error     <= error_d;
         if (state == IDLE && start) begin
            key_q <= key_in;
            msg_q <= msg_in;
         end
         // The read data is valid at the edge that ends each read beat.
         if (state == RD_CT) result[{beat, 5'd0} +: DATA_W] <= bus_rdata;
      end
   end

endmodule
